// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN engine's result-memory bus and the
// maxpool/flatten stage (memory-select encodings, stage FSM states, widths).
package cnn_pkg;

  localparam int CNN_DW = 20;  // signed 4.16 fixed point
  localparam int CNN_AW = 12;  // result-memory address width

  // Result-memory select encodings on csel
  localparam logic [2:0] CSEL_NONE = 3'd0;
  localparam logic [2:0] CSEL_L0K0 = 3'd1;
  localparam logic [2:0] CSEL_L0K1 = 3'd2;
  localparam logic [2:0] CSEL_L1K0 = 3'd3;
  localparam logic [2:0] CSEL_L1K1 = 3'd4;
  localparam logic [2:0] CSEL_L2F  = 3'd5;

  // Maxpool/flatten stage states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WL1,
    ST_WL2,
    ST_FIN
  } pool_state_t;

endpackage

// File: rtl/pool_max4.sv
// pool_max4: running signed-maximum register for one 2x2 pooling window.
// load takes the first sample, update keeps the larger of register and din,
// clear returns the register to zero between runs.
module pool_max4
  import cnn_pkg::*;
#(
  parameter int DW = CNN_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic          update,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] max_val
);

  // Running max: first sample loads, later samples replace only if larger (signed).
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) begin
      max_val <= '0;
    end else if (clear) begin
      max_val <= '0;
    end else if (load) begin
      max_val <= din;
    end else if (update && ($signed(din) > $signed(max_val))) begin
      max_val <= din;
    end
  end

endmodule

// File: rtl/cnn_maxpool_flatten.sv
// cnn_maxpool_flatten: 2x2 signed max-pool of the two 64x64 L0 maps into the
// 32x32 L1 maps, optionally also writing the k0/k1-interleaved flatten vector
// to L2. Owns the shared result-memory bus only while busy.
// Optional feature: define FLATTEN_EN to add the WL2 (L2 flatten) write.
module cnn_maxpool_flatten
  import cnn_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int DW    = CNN_DW,
  parameter int AW    = CNN_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int            PW     = $clog2(IMG_W / 2);
  localparam logic [PW-1:0] P_LAST = PW'(IMG_W / 2 - 1);

  pool_state_t   state, state_nx;
  logic [1:0]    q;         // position inside the 2x2 window: q[1]=row, q[0]=col
  logic [PW-1:0] pr, pc;    // pooled row / column
  logic          k;         // kernel
  logic          rd_vld;    // cdata_rd carries the sample requested last cycle
  logic [1:0]    q_d;       // window position of that sample
  logic [DW-1:0] max_val;
  logic          last_win;
  logic          win_wr;    // final write of the current window

  assign last_win = k & (pr == P_LAST) & (pc == P_LAST);

`ifdef FLATTEN_EN
  assign win_wr = (state == ST_WL2);
`else
  assign win_wr = (state == ST_WL1);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Window position and k/pr/pc loop counters; pc wraps into pr, pr into k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= '0;
      pr <= '0;
      pc <= '0;
      k  <= 1'b0;
    end else if (state == ST_IDLE) begin
      q  <= '0;
      pr <= '0;
      pc <= '0;
      k  <= 1'b0;
    end else begin
      if (state == ST_RD) q <= q + 2'd1;
      if (win_wr) begin
        pc <= pc + PW'(1);
        if (pc == P_LAST) begin
          pr <= pr + PW'(1);
          if (pr == P_LAST) k <= ~k;
        end
      end
    end
  end

  // Read-data alignment: memory returns data one cycle after crd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld <= 1'b0;
      q_d    <= '0;
    end else begin
      rd_vld <= (state == ST_RD);
      q_d    <= q;
    end
  end

  pool_max4 #(.DW(DW)) u_max (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .load    (rd_vld && (q_d == 2'd0)),
    .update  (rd_vld && (q_d != 2'd0)),
    .din     (cdata_rd),
    .max_val (max_val)
  );

  // Next-state and bus outputs; outputs are a pure function of state so reset clears them at once.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = CSEL_NONE;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RD;
      end
      ST_RD: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = k ? CSEL_L0K1 : CSEL_L0K0;
        caddr_rd = AW'({pr, q[1], pc, q[0]});
        if (q == 2'd3) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        state_nx = ST_WL1;
      end
      ST_WL1: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = k ? CSEL_L1K1 : CSEL_L1K0;
        caddr_wr = AW'({pr, pc});
        cdata_wr = max_val;
`ifdef FLATTEN_EN
        state_nx = ST_WL2;
`else
        state_nx = last_win ? ST_FIN : ST_RD;
`endif
      end
      ST_WL2: begin
`ifdef FLATTEN_EN
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = CSEL_L2F;
        caddr_wr = AW'({pr, pc, k});
        cdata_wr = max_val;
        state_nx = last_win ? ST_FIN : ST_RD;
`else
        state_nx = ST_IDLE;
`endif
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnn_maxpool_flatten.sv
// tb_cnn_maxpool_flatten: randomized L0 images with planted corner cases; a
// behavioural model predicts every read and write the stage must issue and
// the final L1/L2 contents. Build with +define+FLATTEN_EN for the L2 variant.
module tb_cnn_maxpool_flatten;

  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int AW    = 12;
`ifdef FLATTEN_EN
  localparam int EXP_CYC = 14337;
`else
  localparam int EXP_CYC = 12289;
`endif

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  cnn_maxpool_flatten #(.IMG_W(IMG_W), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  // Memories and model state
  logic [DW-1:0] l0      [0:1][0:4095];
  logic [DW-1:0] gold_l1 [0:1][0:1023];
  logic [DW-1:0] cap_l1  [0:1][0:1023];
  logic [DW-1:0] gold_l2 [0:2047];
  logic [DW-1:0] cap_l2  [0:2047];
  txn_t          exp_rd[$];
  txn_t          exp_wr[$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_l1_cnt;
  bit first_wr_arm, first_rd_arm;
  logic [34:0] first_wr;
  logic [14:0] first_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] x);
    return int'({{(32-DW){x[DW-1]}}, x});
  endfunction

  // Memory responder: a read seen in one cycle returns data in the next.
  bit            req_v;
  logic [2:0]    req_sel;
  logic [AW-1:0] req_a;
  always @(negedge clk) begin
    req_v   = crd;
    req_sel = csel;
    req_a   = caddr_rd;
  end
  always @(posedge clk) begin
    #1;
    if (req_v && req_sel == 3'd1)      cdata_rd = l0[0][req_a];
    else if (req_v && req_sel == 3'd2) cdata_rd = l0[1][req_a];
    else                               cdata_rd = DW'($urandom);
  end

  // Compare process: bus invariants and every read/write against the model queues.
  always @(negedge clk) begin
    txn_t t;
    if (!reset) begin
      check("rd_wr_excl", {63'd0, crd & cwr}, 64'd0);
      if (!crd && !cwr) check("csel_idle", {61'd0, csel}, 64'd0);
      if (crd) begin
        if (first_rd_arm) begin
          first_rd     = {csel, caddr_rd};
          first_rd_arm = 1'b0;
        end
        if (exp_rd.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rd_extra: got read sel %0d addr %0d, expected none", csel, caddr_rd);
        end else begin
          t = exp_rd.pop_front();
          check("rd_sel_addr", {49'd0, csel, caddr_rd}, {49'd0, t.sel, t.addr});
        end
      end
      if (cwr) begin
        if (first_wr_arm) begin
          first_wr     = {csel, caddr_wr, cdata_wr};
          first_wr_arm = 1'b0;
        end
        case (csel)
          3'd3: begin cap_l1[0][caddr_wr[9:0]] = cdata_wr; wr_l1_cnt++; end
          3'd4: begin cap_l1[1][caddr_wr[9:0]] = cdata_wr; wr_l1_cnt++; end
          3'd5: cap_l2[caddr_wr[10:0]] = cdata_wr;
          default: ;
        endcase
        if (exp_wr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_extra: got write sel %0d addr %0d, expected none", csel, caddr_wr);
        end else begin
          t = exp_wr.pop_front();
          check("wr_sel_addr_data", {29'd0, csel, caddr_wr, cdata_wr}, {29'd0, t});
        end
      end
    end
  end

  task automatic fill_random();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4096; i++) l0[k][i] = DW'($urandom);
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 1024; i++) begin
      cap_l1[0][i] = 'x;
      cap_l1[1][i] = 'x;
    end
    for (int i = 0; i < 2048; i++) cap_l2[i] = 'x;
  endtask

  // Expected bus traffic: kernel outer, pooled row, pooled column inner; window read row-major.
  task automatic build_model();
    txn_t t;
    int   best, v, a, p;
    exp_rd.delete();
    exp_wr.delete();
    for (int k = 0; k < 2; k++)
      for (int pr = 0; pr < IMG_W / 2; pr++)
        for (int pc = 0; pc < IMG_W / 2; pc++) begin
          best = 0;
          for (int i = 0; i < 4; i++) begin
            a = (2 * pr + i / 2) * IMG_W + 2 * pc + i % 2;
            t.sel  = 3'(1 + k);
            t.addr = AW'(a);
            t.data = '0;
            exp_rd.push_back(t);
            v = sx(l0[k][a]);
            if (i == 0 || v > best) best = v;
          end
          p = pr * (IMG_W / 2) + pc;
          gold_l1[k][p] = DW'(best);
          t.sel  = 3'(3 + k);
          t.addr = AW'(p);
          t.data = DW'(best);
          exp_wr.push_back(t);
`ifdef FLATTEN_EN
          gold_l2[2 * p + k] = DW'(best);
          t.sel  = 3'd5;
          t.addr = AW'(2 * p + k);
          exp_wr.push_back(t);
`endif
        end
  endtask

  task automatic check_mem();
    for (int p = 0; p < 1024; p++) begin
      check($sformatf("l1k0_mem[%0d]", p), {44'd0, cap_l1[0][p]}, {44'd0, gold_l1[0][p]});
      check($sformatf("l1k1_mem[%0d]", p), {44'd0, cap_l1[1][p]}, {44'd0, gold_l1[1][p]});
    end
`ifdef FLATTEN_EN
    for (int p = 0; p < 2048; p++)
      check($sformatf("l2_mem[%0d]", p), {44'd0, cap_l2[p]}, {44'd0, gold_l2[p]});
`endif
  endtask

  // One complete run from a start pulse to done, optionally re-pulsing start mid-run.
  task automatic run_full(input bit pulse_again);
    int cyc, last_wr;
    bit got;
    cyc     = 0;
    last_wr = -1;
    got     = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    while (cyc < 20000) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 1) start = 1'b0;
      if (pulse_again && cyc == 500) start = 1'b1;
      if (pulse_again && cyc == 501) start = 1'b0;
      if (cwr) last_wr = cyc;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("start_to_done_cycles", 64'(cyc), 64'(EXP_CYC));
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
    check("done_after_last_wr", 64'(cyc - last_wr), 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    check_mem();
  endtask

  initial begin
    int busy_cnt, guard;
    reset        = 1'b1;
    start        = 1'b0;
    cdata_rd     = '0;
    first_wr_arm = 1'b0;
    first_rd_arm = 1'b0;
    wr_l1_cnt    = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {13'd0, busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}, 64'd0);
    @(negedge clk) reset = 1'b0;

    // Idle with start low
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy || done) busy_cnt++;
    end
    check("idle_busy_cycles", 64'(busy_cnt), 64'd0);

    // Run 1: random image with planted windows, extra start pulse mid-run
    fill_random();
    l0[0][0]    = 20'h00005; l0[0][1]    = 20'h00009;
    l0[0][64]   = 20'h00003; l0[0][65]   = 20'h00007;
    l0[0][2]    = 20'hFFFFF; l0[0][3]    = 20'h00000;
    l0[0][66]   = 20'h80000; l0[0][67]   = 20'hFFFFE;
    l0[1][4030] = 20'h00001; l0[1][4031] = 20'h00002;
    l0[1][4094] = 20'h00003; l0[1][4095] = 20'h7FFFF;
    build_model();
    check("model_pin_l1k0_0", {44'd0, gold_l1[0][0]}, 64'h9);
    check("model_pin_signed", {44'd0, gold_l1[0][1]}, 64'h0);
    check("model_pin_l1k1_1023", {44'd0, gold_l1[1][1023]}, 64'h7FFFF);
    clear_cap();
    first_wr_arm = 1'b1;
    run_full(1'b1);
    check("first_write", {29'd0, first_wr}, {29'd0, 3'd3, 12'd0, 20'h00009});
    check("lit_l1k0_0", {44'd0, cap_l1[0][0]}, 64'h9);
    check("lit_l1k0_signed", {44'd0, cap_l1[0][1]}, 64'h0);
    check("lit_l1k1_1023", {44'd0, cap_l1[1][1023]}, 64'h7FFFF);
`ifdef FLATTEN_EN
    check("lit_l2_0", {44'd0, cap_l2[0]}, 64'h9);
    check("lit_l2_2", {44'd0, cap_l2[2]}, 64'h0);
    check("lit_l2_2047", {44'd0, cap_l2[2047]}, 64'h7FFFF);
`endif

    // Run 2: abort with reset while window 100 is being read
    fill_random();
    build_model();
    wr_l1_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (wr_l1_cnt < 100 && guard < 2000) begin
      @(negedge clk); guard++;
    end
    while (!crd && guard < 2000) begin
      @(negedge clk); guard++;
    end
    check("abort_reached_window_100", {63'd0, (guard < 2000)}, 64'd1);
    #2 reset = 1'b1;
    #1 check("abort_outputs_drop", {57'd0, busy, crd, cwr, done, csel}, 64'd0);
    repeat (3) @(posedge clk);
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk) reset = 1'b0;

    // Run 3: fresh start after the abort must begin at k=0, pr=0, pc=0
    fill_random();
    build_model();
    clear_cap();
    first_rd_arm = 1'b1;
    run_full(1'b0);
    check("restart_first_read", {49'd0, first_rd}, {49'd0, 3'd1, 12'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
